// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage MIPS-like core.
//
// Purpose:
//   Detects load-use data hazards (one-cycle stall with an ID/EX bubble) and
//   control ops (beq/bne/j/jal). A control op opens a flush window that is
//   BUBBLES cycles long, counting the detect cycle. While reset is low, the
//   outputs are forced to their free-running values.
//
// Parameters:
//   DW      instruction width; the opcode is id_instr[DW-1:DW-6]
//   BUBBLES length of the control-hazard window in cycles (1..7)
//   CNTW    width of the statistics counters
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   id_instr     instruction in ID
//   ex_memread   the instruction in EX is a load
//   ex_rt        destination register of the load in EX
//   pc_en        enables the sequential PC+4 update (branch-target writes are not gated)
//   ifid_en      IF/ID register load enable
//   ifid_flush   IF/ID loads a nop
//   idex_flush   ID/EX loads a nop
//   stall        0 = stalled, 1 = free running
//   busy         control-hazard window active
//   stall_cycles count of load-use stall cycles, saturating   (HAZARD_STATS_EN only)
//   flush_cycles count of cycles with ifid_flush=1, saturating (HAZARD_STATS_EN only)
//
// Optional feature macro: HAZARD_STATS_EN adds the two statistics counters.
module hazard_ctrl #(
  parameter int unsigned DW      = 32,
  parameter int unsigned BUBBLES = 3,
  parameter int unsigned CNTW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] id_instr,
  input  logic          ex_memread,
  input  logic [4:0]    ex_rt,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          stall,
  output logic          busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_cycles
`endif
);

  typedef enum logic {RUN, CTRL} state_t;

  // The detect cycle and the final CTRL cycle both count toward the window,
  // so the counter is loaded with BUBBLES-2.
  localparam logic [2:0] CNT_INIT = (BUBBLES > 1) ? 3'(BUBBLES - 2) : 3'd0;

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       ctrl_op, load_use, rt_is_src;
  logic       unused_bits;

  assign opcode      = id_instr[DW-1:DW-6];
  assign rs          = id_instr[25:21];
  assign rt          = id_instr[20:16];
  assign unused_bits = ^id_instr;

  assign ctrl_op   = (opcode == 6'b000100) || (opcode == 6'b000101) ||
                     (opcode == 6'b000010) || (opcode == 6'b000011);
  // rt is only a source operand for R-type, beq, bne and sw.
  assign rt_is_src = (opcode == 6'b000000) || (opcode == 6'b000100) ||
                     (opcode == 6'b000101) || (opcode == 6'b101011);
  assign load_use  = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == rs) || ((ex_rt == rt) && rt_is_src));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall      = 1'b1;
    busy       = 1'b0;
    unique case (state)
      RUN: begin
        if (load_use) begin
          // Load-use takes priority; a pending control op is seen again next cycle.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall      = 1'b0;
        end else if (ctrl_op) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          stall      = 1'b0;
          if (BUBBLES > 1) begin
            state_nx = CTRL;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      CTRL: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        stall      = 1'b0;
        busy       = 1'b1;
        if (cnt == 3'd0) state_nx = RUN;
        else             cnt_nx   = cnt - 3'd1;
      end
      default: state_nx = RUN;
    endcase
    if (!reset) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      stall      = 1'b1;
      busy       = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if ((state == RUN) && load_use && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && (flush_cycles != '1))
        flush_cycles <= flush_cycles + 1'b1;
    end
  end
`else
  localparam int unsigned unused_cntw = CNTW;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [5:0] NORM = 6'b110010; // {pc_en,ifid_en,ifid_flush,idex_flush,stall,busy}
  localparam logic [5:0] LUV  = 6'b000100;
  localparam logic [5:0] DET  = 6'b011000;
  localparam logic [5:0] CTV  = 6'b011001;

  localparam logic [31:0] BEQ = 32'h1022_0003;
  localparam logic [31:0] ADD = 32'h0044_1820;
  localparam logic [31:0] JMP = 32'h0800_0010;
  localparam logic [31:0] LW  = 32'h8C62_0000;
  localparam logic [31:0] SW  = 32'hAC62_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id_instr = '0;
  logic        ex_memread = 1'b0;
  logic [4:0]  ex_rt = '0;

  logic [2:0] pc_en_w, ifid_en_w, ifid_flush_w, idex_flush_w, stall_w, busy_w;
`ifdef HAZARD_STATS_EN
  logic [3:0] sc_w [3];
  logic [3:0] fc_w [3];
`endif

  int checks = 0;
  int failures = 0;
  int rem [3] = '{0, 0, 0};
  int scnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_ctrl #(.DW(32), .BUBBLES(3), .CNTW(4)) u_b3 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_en(pc_en_w[0]), .ifid_en(ifid_en_w[0]), .ifid_flush(ifid_flush_w[0]),
    .idex_flush(idex_flush_w[0]), .stall(stall_w[0]), .busy(busy_w[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc_w[0]), .flush_cycles(fc_w[0])
`endif
  );

  hazard_ctrl #(.DW(32), .BUBBLES(1), .CNTW(4)) u_b1 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_en(pc_en_w[1]), .ifid_en(ifid_en_w[1]), .ifid_flush(ifid_flush_w[1]),
    .idex_flush(idex_flush_w[1]), .stall(stall_w[1]), .busy(busy_w[1])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc_w[1]), .flush_cycles(fc_w[1])
`endif
  );

  hazard_ctrl #(.DW(32), .BUBBLES(7), .CNTW(4)) u_b7 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_en(pc_en_w[2]), .ifid_en(ifid_en_w[2]), .ifid_flush(ifid_flush_w[2]),
    .idex_flush(idex_flush_w[2]), .stall(stall_w[2]), .busy(busy_w[2])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc_w[2]), .flush_cycles(fc_w[2])
`endif
  );

  function automatic int bval(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 7;
  endfunction

  function automatic logic [5:0] outs(input int i);
    return {pc_en_w[i], ifid_en_w[i], ifid_flush_w[i], idex_flush_w[i], stall_w[i], busy_w[i]};
  endfunction

  // Reference decode, straight from the instruction fields.
  function automatic bit is_lu();
    logic [5:0] op;
    op = id_instr[31:26];
    if (!ex_memread || ex_rt == 5'd0) return 0;
    if (ex_rt == id_instr[25:21]) return 1;
    return (ex_rt == id_instr[20:16]) && (op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'd43);
  endfunction

  function automatic bit is_ctl();
    logic [5:0] op;
    op = id_instr[31:26];
    return op == 6'd4 || op == 6'd5 || op == 6'd2 || op == 6'd3;
  endfunction

  // rem = remaining window cycles after the detect cycle.
  function automatic logic [5:0] expv(input int i);
    if (!reset) return NORM;
    if (rem[i] > 0) return CTV;
    if (is_lu()) return LUV;
    if (is_ctl()) return DET;
    return NORM;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state advance.
  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        rem[i]  <= 0;
        scnt[i] <= 0;
        fcnt[i] <= 0;
      end else begin
        if (rem[i] == 0 && is_lu() && scnt[i] < 15) scnt[i] <= scnt[i] + 1;
        if (expv(i) & 6'b001000) fcnt[i] <= (fcnt[i] < 15) ? fcnt[i] + 1 : 15;
        if (rem[i] > 0) rem[i] <= rem[i] - 1;
        else if (!is_lu() && is_ctl()) rem[i] <= bval(i) - 1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cmp_outs_b%0d", bval(i)), {26'd0, outs(i)}, {26'd0, expv(i)});
`ifdef HAZARD_STATS_EN
      chk($sformatf("cmp_stall_cycles_b%0d", bval(i)), {28'd0, sc_w[i]}, scnt[i]);
      chk($sformatf("cmp_flush_cycles_b%0d", bval(i)), {28'd0, fc_w[i]}, fcnt[i]);
`endif
    end
  end

  task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] r);
    @(posedge clk);
    #1;
    id_instr   = ins;
    ex_memread = mr;
    ex_rt      = r;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int i, input logic [5:0] exp);
    chk(nm, {26'd0, outs(i)}, {26'd0, exp});
  endtask

  int n7;

  initial begin
    #1 reset = 1'b0;
    // Reset with hazard inputs present: outputs must stay at free-running values.
    drive(ADD, 1'b1, 5'd2);
    lit("reset_force_b3", 0, NORM);
    drive(BEQ, 1'b0, 5'd0);
    lit("reset_force_b7", 2, NORM);
    @(posedge clk); #1;
    reset = 1'b1;
    id_instr = '0;
    @(negedge clk);
    lit("after_reset_b3", 0, NORM);

    // Load-use via rs, then released, then ex_rt=0.
    drive(ADD, 1'b1, 5'd2);
    lit("lu_add_b3", 0, LUV);
    lit("lu_add_b1", 1, LUV);
    drive(ADD, 1'b0, 5'd2);
    lit("lu_gone", 0, NORM);
    drive(ADD, 1'b1, 5'd0);
    lit("lu_rt0", 0, NORM);
    drive(LW, 1'b1, 5'd2);
    lit("lu_lw_rt_dest", 0, NORM);
    drive(SW, 1'b1, 5'd2);
    lit("lu_sw_rt_src", 0, LUV);

    // beq window, BUBBLES=3.
    drive(BEQ, 1'b0, 5'd0);
    lit("beq_c1", 0, DET);
    lit("beq_c1_b1", 1, DET);
    drive('0, 1'b0, 5'd0);
    lit("beq_c2", 0, CTV);
    lit("beq_c2_b1", 1, NORM);
    drive('0, 1'b0, 5'd0);
    lit("beq_c3", 0, CTV);
    drive('0, 1'b0, 5'd0);
    lit("beq_c4", 0, NORM);
    repeat (5) drive('0, 1'b0, 5'd0);

    // Load-use together with beq.
    drive(BEQ, 1'b1, 5'd1);
    lit("sim_c1", 0, LUV);
    drive(BEQ, 1'b0, 5'd0);
    lit("sim_c2", 0, DET);
    drive('0, 1'b0, 5'd0);
    lit("sim_c3", 0, CTV);
    drive('0, 1'b0, 5'd0);
    lit("sim_c4", 0, CTV);
    drive('0, 1'b0, 5'd0);
    lit("sim_c5", 0, NORM);
    repeat (5) drive('0, 1'b0, 5'd0);

    // j: single flush cycle at BUBBLES=1, 7-cycle window at BUBBLES=7.
    drive(JMP, 1'b0, 5'd0);
    lit("j_b1_c1", 1, DET);
    n7 = (stall_w[2] == 1'b0) ? 1 : 0;
    drive('0, 1'b0, 5'd0);
    lit("j_b1_c2", 1, NORM);
    for (int k = 0; k < 9; k++) begin
      if (stall_w[2] == 1'b0) n7++;
      drive('0, 1'b0, 5'd0);
    end
    chk("b7_window_len", n7, 7);

    // Reset in the middle of a window.
    drive(BEQ, 1'b0, 5'd0);
    drive('0, 1'b0, 5'd0);
    lit("rst_mid_inwin", 0, CTV);
    #2 reset = 1'b0;
    #1 lit("rst_mid_forced_b3", 0, NORM);
    lit("rst_mid_forced_b7", 2, NORM);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive('0, 1'b0, 5'd0);
      lit("rst_mid_no_residual", 0, NORM);
    end

    // Two load-use cycles, then 20 control windows.
    drive(ADD, 1'b1, 5'd2);
    drive(ADD, 1'b1, 5'd2);
    drive('0, 1'b0, 5'd0);
    for (int w = 0; w < 20; w++) begin
      drive(JMP, 1'b0, 5'd0);
      repeat (7) drive('0, 1'b0, 5'd0);
    end
`ifdef HAZARD_STATS_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stats_stall_b%0d", bval(i)), {28'd0, sc_w[i]}, 2);
      chk($sformatf("stats_flush_sat_b%0d", bval(i)), {28'd0, fc_w[i]}, 15);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter DW, default 32, meaning instruction width; opcode is id_instr[DW-1:DW-6].
REQ-002 SHALL provide parameter BUBBLES, default 3, legal 1..7, meaning control-hazard stall window length in cycles.
REQ-003 SHALL provide parameter CNTW, default 16, meaning statistics counter width.
REQ-004 SHALL provide the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_instr  in  DW  instruction currently in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- pc_en  out  1  1 = PC sequential update allowed.
- ifid_en  out  1  1 = IF/ID register may load.
- ifid_flush  out  1  1 = IF/ID loads 32'b0 (nop).
- idex_flush  out  1  1 = ID/EX loads 32'b0 (nop).
- stall  out  1  0 = pipeline stalled, 1 = free running.
- busy  out  1  1 = control-hazard window active (state CTRL).

Function
REQ-005 SHALL decode control op when opcode is 000100 (beq), 000101 (bne), 000010 (j) or 000011 (jal).
REQ-006 SHALL decode load-use when ex_memread=1, ex_rt!=0, and either ex_rt==id_instr[25:21], or ex_rt==id_instr[20:16] with opcode in {000000, 000100, 000101, 101011}.
REQ-007 SHALL implement FSM states RUN and CTRL plus a 3-bit down-counter cnt.
REQ-008 In RUN with load-use: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, stall=0, state stays RUN, combinational in the same cycle.
REQ-009 In RUN with control op and no load-use: pc_en=0, ifid_flush=1, stall=0; if BUBBLES>1, next state CTRL with cnt=BUBBLES-2; if BUBBLES=1, stay RUN.
REQ-010 Load-use and control op together: load-use behaviour wins; the control op is re-evaluated next cycle once the load leaves EX.
REQ-011 In CTRL: pc_en=0, ifid_flush=1, stall=0, busy=1; inputs ignored; if cnt==0, next state RUN, else decrement cnt.
REQ-012 Total stall window for one control op SHALL be exactly BUBBLES cycles, including the detect cycle.
REQ-013 No hazard in RUN: pc_en=1, ifid_en=1, both flushes 0, stall=1, busy=0.
REQ-014 Branch-target writes into PC are not gated by pc_en; pc_en gates PC+4 only.
REQ-015 ifid_flush=1 and ifid_en=0 SHALL never be asserted together.

Reset
REQ-016 While reset=0, the block SHALL enter RUN asynchronously with cnt=0.
REQ-017 While reset=0, outputs SHALL be forced to pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, stall=1, busy=0, regardless of inputs.
REQ-018 Reset asserted mid-CTRL SHALL abort the window; after release, operation restarts from RUN with no residual bubbles.

Configuration
REQ-019 With macro HAZARD_STATS_EN defined, the block SHALL add outputs stall_cycles and flush_cycles, each CNTW bits.
REQ-020 stall_cycles SHALL count cycles with load-use stall; flush_cycles SHALL count cycles with ifid_flush=1.
REQ-021 Both statistics counters SHALL saturate at all-ones and clear on reset.
REQ-022 With HAZARD_STATS_EN undefined, those ports and counters SHALL be absent, with identical remaining behaviour.

Verification
REQ-023 beq (0x10220003) in ID, BUBBLES=3 -> stall=0 and ifid_flush=1 for exactly 3 cycles, busy=1 in cycles 2-3, then stall=1.
REQ-024 ex_memread=1, ex_rt=2, id_instr add $3,$2,$4 (0x00441820) -> one cycle pc_en=0, ifid_en=0, idex_flush=1; ex_rt=0 with the same instruction -> no stall.
REQ-025 Simultaneous case: ex_memread=1, ex_rt=1, id_instr beq $1,$2 -> cycle 1 is a load-use stall, cycles 2-4 are the control window (BUBBLES=3).
REQ-026 reset driven low in cycle 2 of the window -> outputs immediately return to their reset values; after release, no flush occurs.
REQ-027 BUBBLES=1, j (0x08000010) -> a single flush cycle with busy never 1; BUBBLES=7 -> a 7-cycle window.
REQ-028 With HAZARD_STATS_EN and CNTW=4, run 20 control windows -> flush_cycles=15 (saturated).
